// File: rtl/campfire_pkg.sv
// Shared types and constants for the campfire checkpoint bank.
package campfire_pkg;

  localparam int CAMPFIRE_COORD_W = 10;

  typedef enum logic [1:0] {
    UNLIT    = 2'd0,
    KINDLING = 2'd1,
    LIT      = 2'd2
  } fire_state_t;

endpackage

// File: rtl/campfire_channel.sv
// One campfire: box collision test, dwell counter and lighting FSM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// UNLIT    | fire out, dwell counter at 0
// KINDLING | player has stood in the box for dwell_cnt consecutive edges
// LIT      | fire burning; held until level clear or reset
module campfire_channel
  import campfire_pkg::*;
#(
  parameter int COORD_W      = CAMPFIRE_COORD_W,
  parameter int DWELL_CYCLES = 30
) (
  input  logic               sim_clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  input  logic [COORD_W-1:0] box_w,
  input  logic [COORD_W-1:0] box_h,
  output logic               overlap,
  output logic               lit,
  output logic               light_now
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  // Count value from which one more overlapped edge completes the dwell.
  // With a dwell of 1 this is 0, so an UNLIT channel lights immediately.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  fire_state_t      state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [COORD_W:0] x_hi;
  logic [COORD_W:0] y_hi;

  // Inclusive box test; the far edges carry an extra bit so boxes at the
  // top of the coordinate range never wrap.
  always_comb begin
    x_hi      = {1'b0, box_x} + {1'b0, box_w};
    y_hi      = {1'b0, box_y} + {1'b0, box_h};
    overlap   = (pos_x >= box_x) && ({1'b0, pos_x} <= x_hi) &&
                (pos_y >= box_y) && ({1'b0, pos_y} <= y_hi);
    lit       = (state == LIT);
    light_now = overlap && (state != LIT) && (dwell_cnt == LAST_CNT) && !clear;
  end

  // Lighting FSM with dwell counter; level clear acts like reset here.
  always_ff @(posedge sim_clk) begin
    if (reset || clear) begin
      state     <= UNLIT;
      dwell_cnt <= '0;
    end else begin
      case (state)
        LIT: begin
          state     <= LIT;
          dwell_cnt <= '0;
        end
        default: begin
          if (!overlap) begin
            state     <= UNLIT;
            dwell_cnt <= '0;
          end else if (dwell_cnt == LAST_CNT) begin
            state     <= LIT;
            dwell_cnt <= '0;
          end else begin
            state     <= KINDLING;
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/campfire_bank.sv
// Bank of campfire channels with checkpoint tracking and respawn target.
module campfire_bank
  import campfire_pkg::*;
#(
  parameter int NUM_FIRES    = 4,
  parameter int COORD_W      = CAMPFIRE_COORD_W,
  parameter int DWELL_CYCLES = 30,
  parameter int DEFAULT_X    = 16,
  parameter int DEFAULT_Y    = 16,
  localparam int IDX_W       = (NUM_FIRES > 1) ? $clog2(NUM_FIRES) : 1
) (
  input  logic                         sim_clk,
  input  logic                         reset,
  input  logic [2*COORD_W-1:0]         playerPos,
  input  logic [NUM_FIRES*COORD_W-1:0] fire_x,
  input  logic [NUM_FIRES*COORD_W-1:0] fire_y,
  input  logic [NUM_FIRES*COORD_W-1:0] fire_w,
  input  logic [NUM_FIRES*COORD_W-1:0] fire_h,
  input  logic                         level_clear,
  input  logic                         player_dead,
  output logic [NUM_FIRES-1:0]         overlap,
  output logic [NUM_FIRES-1:0]         fire_lit,
  output logic                         checkpoint_valid,
  output logic [IDX_W-1:0]             checkpoint_idx,
  output logic [2*COORD_W-1:0]         respawn_pos,
  output logic                         respawn_valid,
  output logic                         heal_pulse
);

  localparam logic [2*COORD_W-1:0] DEFAULT_POS =
    {COORD_W'(DEFAULT_X), COORD_W'(DEFAULT_Y)};

  logic [NUM_FIRES-1:0] light_now;
  logic [IDX_W-1:0]     light_idx;
  logic [COORD_W-1:0]   cp_x;
  logic [COORD_W-1:0]   cp_y;

  for (genvar g = 0; g < NUM_FIRES; g++) begin : g_fire
    campfire_channel #(
      .COORD_W      (COORD_W),
      .DWELL_CYCLES (DWELL_CYCLES)
    ) u_channel (
      .sim_clk   (sim_clk),
      .reset     (reset),
      .clear     (level_clear),
      .pos_x     (playerPos[2*COORD_W-1:COORD_W]),
      .pos_y     (playerPos[COORD_W-1:0]),
      .box_x     (fire_x[g*COORD_W +: COORD_W]),
      .box_y     (fire_y[g*COORD_W +: COORD_W]),
      .box_w     (fire_w[g*COORD_W +: COORD_W]),
      .box_h     (fire_h[g*COORD_W +: COORD_W]),
      .overlap   (overlap[g]),
      .lit       (fire_lit[g]),
      .light_now (light_now[g])
    );
  end

  // Lowest-index channel lighting this edge wins the checkpoint.
  always_comb begin
    light_idx = '0;
    for (int i = NUM_FIRES - 1; i >= 0; i--) begin
      if (light_now[i]) light_idx = IDX_W'(i);
    end
  end

  // Origin of the fire currently held as checkpoint.
  always_comb begin
    cp_x = '0;
    cp_y = '0;
    for (int i = 0; i < NUM_FIRES; i++) begin
      if (checkpoint_idx == IDX_W'(i)) begin
        cp_x = fire_x[i*COORD_W +: COORD_W];
        cp_y = fire_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Checkpoint and respawn registers; respawn reads the pre-edge checkpoint.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      checkpoint_valid <= 1'b0;
      checkpoint_idx   <= '0;
      respawn_pos      <= DEFAULT_POS;
      respawn_valid    <= 1'b0;
      heal_pulse       <= 1'b0;
    end else if (level_clear) begin
      checkpoint_valid <= 1'b0;
      checkpoint_idx   <= '0;
      respawn_valid    <= 1'b0;
      heal_pulse       <= 1'b0;
    end else begin
      respawn_valid <= player_dead;
      heal_pulse    <= (|light_now) || player_dead;
      if (player_dead) begin
        respawn_pos <= checkpoint_valid ? {cp_x, cp_y} : DEFAULT_POS;
      end
      if (|light_now) begin
        checkpoint_valid <= 1'b1;
        checkpoint_idx   <= light_idx;
      end
    end
  end

endmodule

// File: tb/tb_campfire_bank.sv
// Directed bench for campfire_bank: 4 fires, dwell of 4 edges.
module tb_campfire_bank;

  localparam int NF = 4;
  localparam int CW = 10;

  logic              sim_clk = 1'b0;
  logic              reset;
  logic [2*CW-1:0]   playerPos;
  logic [NF*CW-1:0]  fire_x, fire_y, fire_w, fire_h;
  logic              level_clear;
  logic              player_dead;
  logic [NF-1:0]     overlap;
  logic [NF-1:0]     fire_lit;
  logic              checkpoint_valid;
  logic [1:0]        checkpoint_idx;
  logic [2*CW-1:0]   respawn_pos;
  logic              respawn_valid;
  logic              heal_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2*CW-1:0] POS_DEF   = {10'd16, 10'd16};
  localparam logic [2*CW-1:0] POS_FIRE1 = {10'd100, 10'd200};

  campfire_bank #(
    .NUM_FIRES    (NF),
    .COORD_W      (CW),
    .DWELL_CYCLES (4),
    .DEFAULT_X    (16),
    .DEFAULT_Y    (16)
  ) dut (
    .sim_clk          (sim_clk),
    .reset            (reset),
    .playerPos        (playerPos),
    .fire_x           (fire_x),
    .fire_y           (fire_y),
    .fire_w           (fire_w),
    .fire_h           (fire_h),
    .level_clear      (level_clear),
    .player_dead      (player_dead),
    .overlap          (overlap),
    .fire_lit         (fire_lit),
    .checkpoint_valid (checkpoint_valid),
    .checkpoint_idx   (checkpoint_idx),
    .respawn_pos      (respawn_pos),
    .respawn_valid    (respawn_valid),
    .heal_pulse       (heal_pulse)
  );

  always #5 sim_clk = ~sim_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge sim_clk);
      #1;
    end
  endtask

  task automatic put(input logic [9:0] x, input logic [9:0] y);
    playerPos = {x, y};
  endtask

  task automatic set_fire(input int i, input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] w, input logic [9:0] h);
    fire_x[i*CW +: CW] = x;
    fire_y[i*CW +: CW] = y;
    fire_w[i*CW +: CW] = w;
    fire_h[i*CW +: CW] = h;
  endtask

  initial begin
    reset = 1'b1; level_clear = 1'b0; player_dead = 1'b0;
    fire_x = '0; fire_y = '0; fire_w = '0; fire_h = '0;
    set_fire(0, 300, 300, 10, 10);
    set_fire(1, 100, 200, 20, 10);
    set_fire(2, 500, 500, 5, 5);
    set_fire(3, 1020, 0, 10, 10);
    put(0, 0);
    tick(2);
    reset = 1'b0;

    // reset state
    chk("rst_lit", fire_lit, 4'b0000);
    chk("rst_cpv", checkpoint_valid, 1'b0);
    chk("rst_cpi", checkpoint_idx, 2'd0);
    chk("rst_pos", respawn_pos, POS_DEF);
    chk("rst_rv", respawn_valid, 1'b0);
    chk("rst_heal", heal_pulse, 1'b0);

    // boundary overlap near the top of the coordinate range
    put(1023, 5); #1;
    chk("ovl_1023", overlap, 4'b1000);
    put(1019, 5); #1;
    chk("ovl_1019", overlap, 4'b0000);
    put(1020, 10); #1;
    chk("ovl_corner", overlap, 4'b1000);
    put(110, 211); #1;
    chk("ovl_below", overlap, 4'b0000);
    put(0, 0);

    // respawn with no checkpoint
    player_dead = 1'b1; tick(); player_dead = 1'b0;
    chk("rsp0_v", respawn_valid, 1'b1);
    chk("rsp0_pos", respawn_pos, POS_DEF);
    chk("rsp0_heal", heal_pulse, 1'b1);
    tick();
    chk("rsp0_v_off", respawn_valid, 1'b0);
    chk("rsp0_heal_off", heal_pulse, 1'b0);
    chk("rsp0_hold", respawn_pos, POS_DEF);

    // interrupted dwell: 3 in, 1 out, then 4 in
    put(110, 205); #1;
    chk("ovl_f1", overlap, 4'b0010);
    tick(3);
    chk("dw3_lit", fire_lit, 4'b0000);
    put(0, 0); tick();
    put(110, 205); tick(3);
    chk("dw2_3_lit", fire_lit, 4'b0000);
    chk("dw2_3_heal", heal_pulse, 1'b0);
    tick();
    chk("dw2_4_lit", fire_lit, 4'b0010);
    chk("dw2_4_cpi", checkpoint_idx, 2'd1);
    chk("dw2_4_cpv", checkpoint_valid, 1'b1);
    chk("dw2_4_heal", heal_pulse, 1'b1);
    tick();
    chk("lit_heal_off", heal_pulse, 1'b0);
    chk("lit_hold", fire_lit, 4'b0010);

    // respawn at fire 1
    player_dead = 1'b1; tick(); player_dead = 1'b0;
    chk("rsp1_v", respawn_valid, 1'b1);
    chk("rsp1_pos", respawn_pos, POS_FIRE1);
    tick();

    // clear, then fires 1 and 2 overlapping and lighting together
    level_clear = 1'b1; tick(); level_clear = 1'b0;
    chk("clr_lit", fire_lit, 4'b0000);
    chk("clr_cpv", checkpoint_valid, 1'b0);
    set_fire(2, 105, 200, 20, 10);
    tick(3);
    chk("dual_3_lit", fire_lit, 4'b0000);
    tick();
    chk("dual_lit", fire_lit, 4'b0110);
    chk("dual_cpi", checkpoint_idx, 2'd1);
    chk("dual_heal", heal_pulse, 1'b1);
    tick();
    chk("dual_heal_off", heal_pulse, 1'b0);

    // death on the edge fire 0 lights: respawn uses old checkpoint
    put(305, 305); tick(3);
    player_dead = 1'b1; tick(); player_dead = 1'b0;
    chk("co_lit", fire_lit, 4'b0111);
    chk("co_cpi", checkpoint_idx, 2'd0);
    chk("co_pos", respawn_pos, POS_FIRE1);
    chk("co_rv", respawn_valid, 1'b1);
    chk("co_heal", heal_pulse, 1'b1);
    tick();

    // level clear beats player death
    level_clear = 1'b1; player_dead = 1'b1; tick();
    level_clear = 1'b0; player_dead = 1'b0;
    chk("lcd_lit", fire_lit, 4'b0000);
    chk("lcd_cpv", checkpoint_valid, 1'b0);
    chk("lcd_rv", respawn_valid, 1'b0);
    chk("lcd_heal", heal_pulse, 1'b0);
    chk("lcd_pos", respawn_pos, POS_FIRE1);

    // reset mid-kindling with a coincident death request
    tick(2);
    reset = 1'b1; player_dead = 1'b1; tick();
    reset = 1'b0; player_dead = 1'b0;
    chk("rk_rv", respawn_valid, 1'b0);
    chk("rk_pos", respawn_pos, POS_DEF);
    tick(3);
    chk("rk_3_lit", fire_lit, 4'b0000);
    tick();
    chk("rk_4_lit", fire_lit, 4'b0001);
    chk("rk_4_cpi", checkpoint_idx, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
